mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single-port, 1-cycle-latency byte-masked memory between two requesters: port 0 (instruction fetch) and port 1 (load/store).
- Accepts at most one request per cycle and drives the memory-side addr/rstrb/wmask/wdata combinationally from the granted port.
- Tracks which port owns the in-flight access and routes the response to that port one cycle after acceptance.
- Sits between the core's fetch/LSU units and the memory block.

Parameters:
- ADDR_WIDTH, 32, width of all address buses (passed through unchanged).
- PRIO_MODE, 0, 0 = round-robin between ports; 1 = fixed priority, port 1 always wins.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- req_valid_i  in  2  per-port request valid; bit i = port i.
- req_ready_o  out  2  per-port grant/accept; a transfer occurs when valid[i] & ready[i].
- req_addr0_i  in  ADDR_WIDTH  port 0 byte address.
- req_wmask0_i  in  4  port 0 byte write mask; 0 = read.
- req_wdata0_i  in  32  port 0 write data.
- req_addr1_i  in  ADDR_WIDTH  port 1 byte address.
- req_wmask1_i  in  4  port 1 byte write mask; 0 = read.
- req_wdata1_i  in  32  port 1 write data.
- resp_valid_o  out  2  per-port one-cycle response pulse.
- resp_rdata_o  out  32  read data, shared by both ports; qualified by resp_valid_o.
- mem_addr_o  out  ADDR_WIDTH  to memory address.
- mem_rstrb_o  out  1  to memory read strobe.
- mem_wmask_o  out  4  to memory byte write mask.
- mem_wdata_o  out  32  to memory write data.
- mem_rdata_i  in  32  from memory; registered; valid the cycle after rstrb.

Behaviour:
- Reset values:
  - req_ready_o = 2'b00 and resp_valid_o = 2'b00 while rst = 1.
  - mem_rstrb_o = 0, mem_wmask_o = 0; mem_addr_o and mem_wdata_o driven from port 0.
  - last_grant = 1, so port 0 wins the first contention.
  - pend_valid = 0; any in-flight response is dropped.
- Grant (combinational, every cycle, rst = 0):
  - Only one valid: that port is granted.
  - Both valid, PRIO_MODE = 0: grant the port != last_grant.
  - Both valid, PRIO_MODE = 1: grant port 1.
  - None valid: no grant.
  - req_ready_o = one-hot of the grant; never 2'b11.
- Memory drive:
  - mem_addr_o, mem_wdata_o = granted port's buses (port 0 when idle).
  - mem_wmask_o = granted wmask when granted, else 0.
  - mem_rstrb_o = granted & (granted wmask == 0). Writes never assert rstrb.
- State registers, updated on a grant:
  - last_grant <= granted index.
  - pend_valid <= 1, pend_port <= granted index.
  - With no grant: pend_valid <= 0.
- Response:
  - resp_valid_o[i] = pend_valid & (pend_port == i), exactly one cycle after acceptance, for both reads and writes (write ack).
  - resp_rdata_o = mem_rdata_i, passed through. Meaningful only for read responses; after a write it holds the last read value.
- Pipelining: back-to-back accepts every cycle, no bubbles. Read latency is 1 cycle from accept to resp_valid.
- Ordering: responses return in acceptance order. Requesters must hold addr/wmask/wdata stable while valid & !ready.
- Starvation: in round-robin mode a port waits at most 1 cycle under continuous contention. In fixed mode port 0 may starve (by design).
- Address: passed through unmodified. Alignment is the requester's responsibility.

Test Plan:
- Reset, then port 0 read addr 0x10 alone → ready = 01 same cycle, rstrb = 1, addr 0x10; next cycle resp_valid = 01, rdata = MEM[0x10].
- Port 1 write addr 0x20, wdata 0xDEADBEEF, wmask 1111; next cycle port 1 read 0x20 → write-ack resp_valid = 10; then read response 0xDEADBEEF with resp_valid = 10.
- Both ports read continuously for 6 cycles, PRIO_MODE = 0 → grants alternate 01,10,01,10,…; each response routed to the correct port one cycle later.
- PRIO_MODE = 1, both valid for 4 cycles → ready = 10 all 4 cycles; port 0 ready = 0 throughout; port 0 granted the cycle port 1 drops valid.
- Port 1 write wmask 0010, wdata 0x0000AB00 to 0x30 (pre-zeroed) → mem_rstrb_o = 0 that cycle; later read 0x30 returns 0x0000AB00.
- Port 0 read accepted, rst asserted next cycle → resp_valid stays 00; after release the first contention grants port 0.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Shares a single-port, 1-cycle-latency, byte-masked memory between an
// instruction-fetch requester (port 0) and a load/store requester (port 1).
// At most one request is accepted per cycle. The memory side is driven
// combinationally from the granted port. The response is routed back to the
// owning port one cycle after acceptance.
//
// Parameters
//   ADDR_WIDTH : width of every address bus (passed through unchanged)
//   PRIO_MODE  : 0 = round-robin, 1 = fixed priority (port 1 always wins)
//
// Ports
//   clk, rst                    : clock, synchronous active-high reset
//   req_valid_i / req_ready_o   : per-port handshake (bit i = port i)
//   req_addr0_i/wmask0/wdata0   : port 0 request (wmask 0 = read)
//   req_addr1_i/wmask1/wdata1   : port 1 request (wmask 0 = read)
//   resp_valid_o                : per-port one-cycle response pulse
//   resp_rdata_o                : shared read data, qualified by resp_valid_o
//   mem_addr_o/rstrb/wmask/wdata: memory request side
//   mem_rdata_i                 : registered memory read data
module mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int PRIO_MODE  = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            req_valid_i,
  output logic [1:0]            req_ready_o,
  input  logic [ADDR_WIDTH-1:0] req_addr0_i,
  input  logic [3:0]            req_wmask0_i,
  input  logic [31:0]           req_wdata0_i,
  input  logic [ADDR_WIDTH-1:0] req_addr1_i,
  input  logic [3:0]            req_wmask1_i,
  input  logic [31:0]           req_wdata1_i,
  output logic [1:0]            resp_valid_o,
  output logic [31:0]           resp_rdata_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic                  mem_rstrb_o,
  output logic [3:0]            mem_wmask_o,
  output logic [31:0]           mem_wdata_o,
  input  logic [31:0]           mem_rdata_i
);

  logic last_grant;   // index of the most recently granted port
  logic pend_valid;   // an access was accepted last cycle
  logic pend_port;    // owner of that access
  logic grant_valid;
  logic grant_idx;
  logic [3:0] grant_wmask;

  // Grant selection; no grant is ever issued while reset is held.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = 1'b0;
    if (!rst) begin
      case (req_valid_i)
        2'b01: begin
          grant_valid = 1'b1;
          grant_idx   = 1'b0;
        end
        2'b10: begin
          grant_valid = 1'b1;
          grant_idx   = 1'b1;
        end
        2'b11: begin
          grant_valid = 1'b1;
          // Round-robin hands contention to the port that did not win last.
          grant_idx   = (PRIO_MODE != 0) ? 1'b1 : ~last_grant;
        end
        default: begin
          grant_valid = 1'b0;
          grant_idx   = 1'b0;
        end
      endcase
    end
  end

  // Handshake and memory-side drive from the granted port (port 0 when idle).
  always_comb begin
    req_ready_o = 2'b00;
    grant_wmask = 4'h0;
    if (grant_valid) begin
      req_ready_o = grant_idx ? 2'b10 : 2'b01;
      grant_wmask = grant_idx ? req_wmask1_i : req_wmask0_i;
    end
    mem_addr_o  = (grant_valid && grant_idx) ? req_addr1_i  : req_addr0_i;
    mem_wdata_o = (grant_valid && grant_idx) ? req_wdata1_i : req_wdata0_i;
    mem_wmask_o = grant_wmask;
    // Writes are acknowledged but never strobe a read.
    mem_rstrb_o = grant_valid && (grant_wmask == 4'h0);
  end

  // Ownership tracking for the in-flight access and round-robin history.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= 1'b1;
      pend_valid <= 1'b0;
      pend_port  <= 1'b0;
    end else if (grant_valid) begin
      last_grant <= grant_idx;
      pend_valid <= 1'b1;
      pend_port  <= grant_idx;
    end else begin
      pend_valid <= 1'b0;
    end
  end

  // Response routing; an access in flight when reset arrives is dropped.
  always_comb begin
    resp_valid_o = 2'b00;
    if (!rst && pend_valid) begin
      resp_valid_o = pend_port ? 2'b10 : 2'b01;
    end
    resp_rdata_o = mem_rdata_i;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req_valid = 2'b00;
  logic [31:0] a0 = 32'h0, a1 = 32'h0, d0 = 32'h0, d1 = 32'h0;
  logic [3:0]  m0 = 4'h0, m1 = 4'h0;

  // round-robin instance outputs
  logic [1:0]  rdy_rr, rv_rr;
  logic [31:0] rdata_rr, maddr_rr, mwdata_rr, mrdata_rr;
  logic        rstrb_rr;
  logic [3:0]  mwmask_rr;
  // fixed-priority instance outputs
  logic [1:0]  rdy_fp, rv_fp;
  logic [31:0] rdata_fp, maddr_fp, mwdata_fp, mrdata_fp;
  logic        rstrb_fp;
  logic [3:0]  mwmask_fp;

  logic [31:0] mem_rr [0:63];
  logic [31:0] mem_fp [0:63];
  logic [31:0] ref_mem [0:63];

  typedef struct {
    logic        port;
    logic        rd;
    logic [31:0] data;
  } exp_t;
  exp_t sb[$];

  int n_assert = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_WIDTH(32), .PRIO_MODE(0)) dut_rr (
    .clk(clk), .rst(rst), .req_valid_i(req_valid), .req_ready_o(rdy_rr),
    .req_addr0_i(a0), .req_wmask0_i(m0), .req_wdata0_i(d0),
    .req_addr1_i(a1), .req_wmask1_i(m1), .req_wdata1_i(d1),
    .resp_valid_o(rv_rr), .resp_rdata_o(rdata_rr),
    .mem_addr_o(maddr_rr), .mem_rstrb_o(rstrb_rr), .mem_wmask_o(mwmask_rr),
    .mem_wdata_o(mwdata_rr), .mem_rdata_i(mrdata_rr));

  mem_arbiter #(.ADDR_WIDTH(32), .PRIO_MODE(1)) dut_fp (
    .clk(clk), .rst(rst), .req_valid_i(req_valid), .req_ready_o(rdy_fp),
    .req_addr0_i(a0), .req_wmask0_i(m0), .req_wdata0_i(d0),
    .req_addr1_i(a1), .req_wmask1_i(m1), .req_wdata1_i(d1),
    .resp_valid_o(rv_fp), .resp_rdata_o(rdata_fp),
    .mem_addr_o(maddr_fp), .mem_rstrb_o(rstrb_fp), .mem_wmask_o(mwmask_fp),
    .mem_wdata_o(mwdata_fp), .mem_rdata_i(mrdata_fp));

  // 1-cycle registered byte-masked memories, one per instance
  always @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (mwmask_rr[b]) mem_rr[maddr_rr[7:2]][8*b +: 8] <= mwdata_rr[8*b +: 8];
      if (mwmask_fp[b]) mem_fp[maddr_fp[7:2]][8*b +: 8] <= mwdata_fp[8*b +: 8];
    end
    if (rstrb_rr) mrdata_rr <= mem_rr[maddr_rr[7:2]];
    if (rstrb_fp) mrdata_fp <= mem_fp[maddr_fp[7:2]];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive, check responses due now, check grant/memory
  // drive of the round-robin instance, optionally check fixed-priority ready.
  task automatic cycle(input logic [1:0] v,
                       input logic [31:0] ia0, input logic [3:0] im0, input logic [31:0] id0,
                       input logic [31:0] ia1, input logic [3:0] im1, input logic [31:0] id1,
                       input logic [1:0] exp_rdy, input logic chk_fp, input logic [1:0] exp_rdy_fp);
    exp_t e;
    logic [1:0]  exp_rv;
    logic [31:0] ea, ed;
    logic [3:0]  em;
    req_valid = v; a0 = ia0; m0 = im0; d0 = id0; a1 = ia1; m1 = im1; d1 = id1;
    @(negedge clk);
    exp_rv = 2'b00;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      exp_rv = e.port ? 2'b10 : 2'b01;
      if (e.rd) chk("resp_rdata", rdata_rr, e.data);
    end
    chk("resp_valid", {30'h0, rv_rr}, {30'h0, exp_rv});
    chk("ready", {30'h0, rdy_rr}, {30'h0, exp_rdy});
    if (chk_fp) chk("ready_fixed", {30'h0, rdy_fp}, {30'h0, exp_rdy_fp});
    ea = exp_rdy[1] ? ia1 : ia0;
    ed = exp_rdy[1] ? id1 : id0;
    em = (exp_rdy == 2'b10) ? im1 : ((exp_rdy == 2'b01) ? im0 : 4'h0);
    chk("mem_addr", maddr_rr, ea);
    chk("mem_wmask", {28'h0, mwmask_rr}, {28'h0, em});
    chk("mem_rstrb", {31'h0, rstrb_rr}, {31'h0, (exp_rdy != 2'b00) && (em == 4'h0)});
    if (em != 4'h0) chk("mem_wdata", mwdata_rr, ed);
    if (exp_rdy != 2'b00) begin
      e.port = exp_rdy[1];
      e.rd   = (em == 4'h0);
      e.data = ref_mem[ea[7:2]];
      sb.push_back(e);
      for (int b = 0; b < 4; b++)
        if (em[b]) ref_mem[ea[7:2]][8*b +: 8] = ed[8*b +: 8];
    end
    @(posedge clk); #1;
  endtask

  // One reset cycle with both ports requesting; nothing may be granted or returned.
  task automatic reset_cycle();
    rst = 1'b1; req_valid = 2'b11;
    @(negedge clk);
    chk("rst_ready", {30'h0, rdy_rr}, 32'h0);
    chk("rst_resp_valid", {30'h0, rv_rr}, 32'h0);
    chk("rst_ready_fixed", {30'h0, rdy_fp}, 32'h0);
    chk("rst_rstrb", {31'h0, rstrb_rr}, 32'h0);
    chk("rst_wmask", {28'h0, mwmask_rr}, 32'h0);
    chk("rst_addr", maddr_rr, a0);
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0; req_valid = 2'b00;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      mem_rr[i]  = 32'hC000_0000 | (32'(i) * 32'h0001_0101);
      mem_fp[i]  = mem_rr[i];
      ref_mem[i] = mem_rr[i];
    end
    mem_rr[12] = 32'h0; mem_fp[12] = 32'h0; ref_mem[12] = 32'h0;   // 0x30 pre-zeroed
    a0 = 32'h0000_0004;
    @(posedge clk); #1;
    reset_cycle();

    // single read from port 0, then port 1 write followed by read-back
    cycle(2'b01, 32'h10, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0, 2'b01, 1'b1, 2'b01);
    cycle(2'b10, 32'h0, 4'h0, 32'h0, 32'h20, 4'hF, 32'hDEAD_BEEF, 2'b10, 1'b1, 2'b10);
    cycle(2'b10, 32'h0, 4'h0, 32'h0, 32'h20, 4'h0, 32'h0, 2'b10, 1'b0, 2'b00);
    cycle(2'b00, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0, 2'b00, 1'b0, 2'b00);
    chk("readback_deadbeef", ref_mem[8], 32'hDEAD_BEEF);

    // continuous contention: round-robin alternates, starting with port 0
    for (int k = 0; k < 6; k++)
      cycle(2'b11, 32'h44, 4'h0, 32'h0, 32'h48, 4'h0, 32'h0,
            (k % 2 == 0) ? 2'b01 : 2'b10, 1'b0, 2'b00);
    cycle(2'b00, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0, 2'b00, 1'b0, 2'b00);

    // fixed priority: port 1 wins every contended cycle, port 0 once port 1 drops
    for (int k = 0; k < 4; k++)
      cycle(2'b11, 32'h14, 4'h0, 32'h0, 32'h18, 4'h0, 32'h0,
            (k % 2 == 0) ? 2'b01 : 2'b10, 1'b1, 2'b10);
    cycle(2'b01, 32'h14, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0, 2'b01, 1'b1, 2'b01);

    // partial byte write never strobes a read; read back merged value
    cycle(2'b10, 32'h0, 4'h0, 32'h0, 32'h30, 4'b0010, 32'h0000_AB00, 2'b10, 1'b0, 2'b00);
    cycle(2'b00, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0, 2'b00, 1'b0, 2'b00);
    cycle(2'b10, 32'h0, 4'h0, 32'h0, 32'h30, 4'h0, 32'h0, 2'b10, 1'b0, 2'b00);
    cycle(2'b00, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0, 2'b00, 1'b0, 2'b00);
    chk("byte_write_merge", ref_mem[12], 32'h0000_AB00);

    // in-flight read dropped by reset; first contention afterwards goes to port 0
    cycle(2'b01, 32'h10, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0, 2'b01, 1'b0, 2'b00);
    reset_cycle();
    cycle(2'b11, 32'h24, 4'h0, 32'h0, 32'h28, 4'h0, 32'h0, 2'b01, 1'b1, 2'b10);
    cycle(2'b00, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0, 2'b00, 1'b0, 2'b00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
